// File: rtl/instr_load_sequencer.sv
// instr_load_sequencer
// Loads the instruction RAM from a UART byte stream and then gates the
// MIPS clock enable according to run commands received on the same stream.
//
// Ports:
//   clka      system clock, all logic on the rising edge
//   reset     synchronous, active-low reset
//   rx_data   received UART byte
//   rx_valid  one-cycle strobe qualifying rx_data
//   halt_in   HALT detect from the RAM for the current fetch address
//   wr_addr   RAM write address (word index)
//   wr_data   RAM write data (word being assembled / written)
//   wr_en     RAM write strobe, one cycle high per word
//   mem_ena   RAM read enable
//   clk_en    MIPS clock enable
//   loading   high while loading words (LOAD and write states)
//   done      high once the program has reached its HALT word
//   overflow  sticky: load filled the RAM without seeing a HALT word
//   rx_lost   sticky: a byte arrived during a write and was dropped
module instr_load_sequencer #(
  parameter int          RAM_WIDTH  = 32,
  parameter int          RAM_DEPTH  = 2048,
  parameter logic [7:0]  CMD_CONT   = 8'h63,
  parameter logic [7:0]  CMD_STEP   = 8'h73,
  parameter logic [7:0]  CMD_RELOAD = 8'h72
) (
  input  logic                 clka,
  input  logic                 reset,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  input  logic                 halt_in,
  output logic [31:0]          wr_addr,
  output logic [RAM_WIDTH-1:0] wr_data,
  output logic                 wr_en,
  output logic                 mem_ena,
  output logic                 clk_en,
  output logic                 loading,
  output logic                 done,
  output logic                 overflow,
  output logic                 rx_lost
);

  typedef enum logic [2:0] {
    LOAD,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    WAIT_CMD,
    RUN,
    STEP,
    DONE
  } state_t;

  localparam logic [31:0] LAST_ADDR = 32'(RAM_DEPTH - 1);

  state_t     state;
  logic [1:0] byte_cnt;
  logic       word_is_halt;

  // A word is HALT when its six opcode bits are all ones.
  assign word_is_halt = &wr_data[RAM_WIDTH-1 -: 6];

  // Single state machine. Every output is a register that is updated on the
  // same edge as the state transition, so each output reflects the state it
  // belongs to. mem_ena stays high through RUN and STEP so the pipeline can
  // fetch while it is clocked.
  always_ff @(posedge clka) begin
    if (!reset) begin
      state    <= LOAD;
      byte_cnt <= 2'd0;
      wr_addr  <= 32'd0;
      wr_data  <= '0;
      wr_en    <= 1'b0;
      mem_ena  <= 1'b0;
      clk_en   <= 1'b0;
      loading  <= 1'b1;
      done     <= 1'b0;
      overflow <= 1'b0;
      rx_lost  <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (rx_valid) begin
            wr_data  <= {wr_data[RAM_WIDTH-9:0], rx_data};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              state <= WR_SETUP;
            end
          end
        end

        WR_SETUP: begin
          if (rx_valid) rx_lost <= 1'b1;
          state <= WR_PULSE;
          wr_en <= 1'b1;
        end

        WR_PULSE: begin
          if (rx_valid) rx_lost <= 1'b1;
          state <= WR_HOLD;
          wr_en <= 1'b0;
        end

        WR_HOLD: begin
          if (rx_valid) rx_lost <= 1'b1;
          // The HALT word keeps its address so wr_addr names the last word.
          if (word_is_halt) begin
            state   <= WAIT_CMD;
            loading <= 1'b0;
            mem_ena <= 1'b1;
          end else if (wr_addr == LAST_ADDR) begin
            overflow <= 1'b1;
            state    <= WAIT_CMD;
            loading  <= 1'b0;
            mem_ena  <= 1'b1;
          end else begin
            wr_addr <= wr_addr + 32'd1;
            state   <= LOAD;
          end
        end

        WAIT_CMD: begin
          if (rx_valid) begin
            if (rx_data == CMD_CONT) begin
              state  <= RUN;
              clk_en <= 1'b1;
            end else if (rx_data == CMD_STEP) begin
              state  <= STEP;
              clk_en <= 1'b1;
            end else if (rx_data == CMD_RELOAD) begin
              state    <= LOAD;
              wr_addr  <= 32'd0;
              byte_cnt <= 2'd0;
              overflow <= 1'b0;
              mem_ena  <= 1'b0;
              loading  <= 1'b1;
            end
          end
        end

        // clk_en is high throughout RUN, so any halt_in here ends the run.
        RUN: begin
          if (halt_in) begin
            state   <= DONE;
            clk_en  <= 1'b0;
            mem_ena <= 1'b0;
            done    <= 1'b1;
          end
        end

        STEP: begin
          clk_en <= 1'b0;
          if (halt_in) begin
            state   <= DONE;
            mem_ena <= 1'b0;
            done    <= 1'b1;
          end else begin
            state <= WAIT_CMD;
          end
        end

        DONE: begin
          if (rx_valid && rx_data == CMD_RELOAD) begin
            state    <= LOAD;
            wr_addr  <= 32'd0;
            byte_cnt <= 2'd0;
            overflow <= 1'b0;
            done     <= 1'b0;
            loading  <= 1'b1;
          end
        end

        default: begin
          state <= LOAD;
        end
      endcase
    end
  end

endmodule
